// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Holds the lookahead group size, the group count helper and the
// add/subtract mode encodings used by the top level and the group cell.
package pipelined_cla_adder_pkg;

    localparam int CLA_GROUP = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Number of 4-bit lookahead groups needed to cover an operand width
    function automatic int groupCount(input int width);
        return width / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group.
// From bitwise propagate/generate and the group carry-in it forms the carries
// into bits 1..3 by full lookahead, plus the group propagate and generate that
// feed the group-carry chain in the top level. Purely combinational.
module cla_group4
    import pipelined_cla_adder_pkg::*;
(
    input  logic [CLA_GROUP-1:0] i_p,
    input  logic [CLA_GROUP-1:0] i_g,
    input  logic                 i_cin,
    output logic [CLA_GROUP-1:1] o_carry,
    output logic                 o_gp,
    output logic                 o_gg
);

    // Full lookahead: every carry is a flat sum of products of P, G and cin
    always_comb begin
        o_carry[1] = i_g[0]
                   | (i_p[0] & i_cin);
        o_carry[2] = i_g[1]
                   | (i_p[1] & i_g[0])
                   | (i_p[1] & i_p[0] & i_cin);
        o_carry[3] = i_g[2]
                   | (i_p[2] & i_g[1])
                   | (i_p[2] & i_p[1] & i_g[0])
                   | (i_p[2] & i_p[1] & i_p[0] & i_cin);
        o_gp       = &i_p;
        o_gg       = i_g[3]
                   | (i_p[3] & i_g[2])
                   | (i_p[3] & i_p[2] & i_g[1])
                   | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// Stage 1 registers the (conditionally inverted) operands and effective
// carry-in; stage 2 registers sum, carry-out and optionally signed overflow.
// Optional feature macro: CLA_OVERFLOW_EN adds the ovf output and register.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NGROUPS = groupCount(WIDTH);

    logic               r_s1Valid;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_cin;

    logic               r_outValid;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_adv1;
    logic               w_adv2;
    logic [WIDTH-1:0]   w_p;
    logic [WIDTH-1:0]   w_g;
    logic [NGROUPS-1:0] w_gp;
    logic [NGROUPS-1:0] w_gg;
    logic [NGROUPS:0]   w_groupCarry;
    logic [NGROUPS*3-1:0] w_inner;
    logic [WIDTH:0]     w_carry;
    logic [WIDTH-1:0]   w_sum;

    // Output stage moves when empty or drained; input stage when it can hand off
    assign w_adv2   = !r_outValid | out_ready;
    assign w_adv1   = !r_s1Valid | w_adv2;
    assign in_ready = w_adv1;

    // Stage 1: capture operands with B inverted and carry forced to 1 for subtract
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
        end else if (w_adv1) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_a   <= a;
                r_b   <= b ^ {WIDTH{sub == MODE_SUB}};
                r_cin <= (sub == MODE_ADD) ? cin : 1'b1;
            end
        end
    end

    assign w_p = r_a ^ r_b;
    assign w_g = r_a & r_b;

    // One lookahead cell per 4-bit slice, each fed by its group carry-in
    generate
        for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
            cla_group4 u_group (
                .i_p     (w_p[gi*CLA_GROUP +: CLA_GROUP]),
                .i_g     (w_g[gi*CLA_GROUP +: CLA_GROUP]),
                .i_cin   (w_groupCarry[gi]),
                .o_carry (w_inner[gi*3 +: 3]),
                .o_gp    (w_gp[gi]),
                .o_gg    (w_gg[gi])
            );
        end
    endgenerate

    // Ripple the group carries across groups using group propagate/generate
    always_comb begin
        w_groupCarry    = '0;
        w_groupCarry[0] = r_cin;
        for (int gi = 0; gi < NGROUPS; gi++) begin
            w_groupCarry[gi+1] = w_gg[gi] | (w_gp[gi] & w_groupCarry[gi]);
        end
    end

    // Assemble the per-bit carry-in vector; bit WIDTH is the final carry-out
    always_comb begin
        w_carry = '0;
        for (int gi = 0; gi < NGROUPS; gi++) begin
            w_carry[gi*CLA_GROUP]           = w_groupCarry[gi];
            w_carry[gi*CLA_GROUP + 1 +: 3]  = w_inner[gi*3 +: 3];
        end
        w_carry[WIDTH] = w_groupCarry[NGROUPS];
    end

    assign w_sum = w_p ^ w_carry[WIDTH-1:0];

    // Stage 2: register the result only when a valid operation moves in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
        end else if (w_adv2) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

`ifdef CLA_OVERFLOW_EN
    logic r_ovf;

    // Signed overflow: carry into the sign bit disagrees with carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv2 && r_s1Valid) begin
            r_ovf <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
        end
    end

    assign ovf = r_ovf;
`endif

    assign out_valid = r_outValid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16).
// A scoreboard queue receives the expected result when an operation is
// accepted and is popped when the DUT hands a result out.
module tb_pipelined_cla_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } expT;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         opCin;
    logic         opSub;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_OVERFLOW_EN
    logic         ovf;
`endif

    int  checks = 0;
    int  errors = 0;
    int  outCount = 0;
    int  outCycles = 0;
    int  accepted = 0;
    expT sb[$];

    logic         prevStall = 1'b0;
    logic [W-1:0] prevSum;
    logic         prevCout;
    logic [W-1:0] heldSum;

    pipelined_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
        .cin       (opCin),
        .sub       (opSub),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Independent arithmetic model of one operation
    function automatic expT model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic s);
        expT          r;
        logic [W-1:0] yE;
        logic         cE;
        logic [W:0]   t;
        yE     = s ? ~y : y;
        cE     = s ? 1'b1 : c;
        t      = {1'b0, x} + {1'b0, yE} + {{W{1'b0}}, cE};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == yE[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic c, input logic s);
        inValid = v;
        opA     = x;
        opB     = y;
        opCin   = c;
        opSub   = s;
    endtask

    // One clock: evaluate handshakes mid-cycle, then advance past the edge
    task automatic tick();
        expT e;
        @(negedge clk);
        if (prevStall) begin
            checkOutput("stall sum stable", 32'(sum), 32'(prevSum));
            checkOutput("stall cout stable", 32'(cout), 32'(prevCout));
        end
        prevStall = outValid && !outReady;
        prevSum   = sum;
        prevCout  = cout;
        if (outValid) outCycles++;
        if (outValid && outReady) begin
            outCount++;
            checkOutput("result expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("sum", 32'(sum), 32'(e.sum));
                checkOutput("cout", 32'(cout), 32'(e.cout));
`ifdef CLA_OVERFLOW_EN
                checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
        if (inValid && inReady) begin
            accepted++;
            sb.push_back(model(opA, opB, opCin, opSub));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        inValid = 1'b0;
        while ((sb.size() != 0 || outValid) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain complete", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        outReady = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #12;
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
`ifdef CLA_OVERFLOW_EN
        checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("in_ready after reset", 32'(inReady), 32'd1);

        // Carry wrap and two-cycle latency
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        inValid = 1'b0;
        checkOutput("latency n+1 out_valid", 32'(outValid), 32'd0);
        tick();
        checkOutput("latency n+2 out_valid", 32'(outValid), 32'd1);
        checkOutput("wrap sum", 32'(sum), 32'h0000);
        checkOutput("wrap cout", 32'(cout), 32'd1);
        drain(10);

        // Subtract with and without borrow, then bubble keeps last result
        applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0007, 16'h0005, 1'b0, 1'b1);
        tick();
        drain(10);
        checkOutput("bubble out_valid", 32'(outValid), 32'd0);
        checkOutput("bubble sum held", 32'(sum), 32'h0002);
        checkOutput("bubble cout held", 32'(cout), 32'd1);

        // Signed overflow corners and a carry-in add
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b0);
        tick();
        drain(10);

        // Throughput: 8 back-to-back adds with out_ready held high
        outCycles = 0;
        accepted  = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(i), 16'h0100, 1'b0, 1'b0);
            tick();
        end
        inValid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("throughput accepted", 32'(accepted), 32'd8);
        checkOutput("throughput out cycles", 32'(outCycles), 32'd8);

        // Backpressure: third operation waits until the consumer drains
        outReady = 1'b0;
        accepted = 0;
        outCount = 0;
        applyStimulus(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b0);
        checkOutput("full in_ready", 32'(inReady), 32'd0);
        heldSum = sum;
        tick();
        tick();
        checkOutput("full held sum", 32'(sum), 32'(heldSum));
        checkOutput("full held sum value", 32'(sum), 32'h0033);
        checkOutput("full accepted", 32'(accepted), 32'd2);
        outReady = 1'b1;
        tick();
        checkOutput("third accepted", 32'(accepted), 32'd3);
        drain(10);
        checkOutput("backpressure results", 32'(outCount), 32'd3);

        // Random mix of modes, bubbles and stalls
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            outReady = ($urandom_range(0, 3) != 0);
            tick();
        end
        outReady = 1'b1;
        drain(20);

        // Reset with two operations in flight discards them immediately
        outReady = 1'b0;
        applyStimulus(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0303, 16'h0404, 1'b0, 1'b0);
        tick();
        inValid = 1'b0;
        checkOutput("pre-reset out_valid", 32'(outValid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset out_valid", 32'(outValid), 32'd0);
        checkOutput("async reset sum", 32'(sum), 32'd0);
        checkOutput("async reset in_ready", 32'(inReady), 32'd1);
        sb.delete();
        prevStall = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        outReady = 1'b1;
        outCount = 0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("no stale result", 32'(outCount), 32'd0);
        checkOutput("post-reset in_ready", 32'(inReady), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
